seg_hex_display: RTL and testbench

Four-digit multiplexed seven-segment driver for the board's display. It is the output-side counterpart of the switch-capture logic: upstream logic presents a byte with a one-cycle `load` strobe. The block latches the byte, counts how many loads have occurred, and continuously scans both values onto a common-anode display as hex digits. A blanking interval at each digit change suppresses ghosting.

---
 rtl/seg_hex_display.sv | 139 +++++++++++++
 tb/tb_seg_hex_display.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_hex_display.sv
// Four-digit multiplexed common-anode hex display driver with per-slot anode blanking.
// Optional build macro SEG_LZB_EN: blank the segments of digit3 when count_q[7:4] is zero.
module seg_hex_display #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int REFRESH_HZ   = 1000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       o_dbg_state
);

  localparam int SLOT = CLK_HZ / REFRESH_HZ;
  localparam int DW   = (SLOT > 2) ? $clog2(SLOT) : 1;
  localparam logic [DW-1:0] DIV_LAST   = DW'(SLOT - 1);
  localparam logic [DW-1:0] BLANK_LAST = DW'(BLANK_CYCLES - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  state_t        r_state;
  logic [DW-1:0] r_div;
  logic [1:0]    r_idx;
  logic [7:0]    r_data;
  logic [7:0]    r_count;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic [3:0]    r_an;

  state_t        w_state_nxt;
  logic [DW-1:0] w_div_nxt;
  logic [1:0]    w_idx_nxt;
  logic [3:0]    w_nib;
  logic [6:0]    w_seg_nxt;
  logic          w_dp_nxt;
  logic [3:0]    w_an_nxt;

  // Active-high segment patterns, bit0 = a .. bit6 = g.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= 8'h00;
      r_count <= 8'h00;
    end else if (load) begin
      r_data  <= data;
      r_count <= r_count + 8'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_div_nxt   = (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
    case (r_state)
      ST_BLANK: if (r_div == BLANK_LAST) w_state_nxt = ST_DRIVE;
      ST_DRIVE: begin
        if (r_div == DIV_LAST) begin
          w_state_nxt = ST_BLANK;
          w_idx_nxt   = r_idx + 2'd1;
        end
      end
      default: w_state_nxt = ST_BLANK;
    endcase
  end

  // Outputs are registered from the next-state view, so they track the state register
  // while the segment data reflects data_q/count_q as of the preceding edge.
  always_comb begin
    w_an_nxt  = 4'hF;
    w_seg_nxt = 7'h7F;
    w_dp_nxt  = 1'b1;
    case (w_idx_nxt)
      2'd0:    w_nib = r_data[3:0];
      2'd1:    w_nib = r_data[7:4];
      2'd2:    w_nib = r_count[3:0];
      default: w_nib = r_count[7:4];
    endcase
    if (w_state_nxt == ST_DRIVE) begin
      w_an_nxt  = ~(4'b0001 << w_idx_nxt);
      w_seg_nxt = ~hex7(w_nib);
      w_dp_nxt  = (w_idx_nxt != 2'd2);
`ifdef SEG_LZB_EN
      if (w_idx_nxt == 2'd3 && r_count[7:4] == 4'h0) w_seg_nxt = 7'h7F;
`else
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_BLANK;
      r_div   <= '0;
      r_idx   <= 2'd0;
      r_seg   <= 7'h7F;
      r_dp    <= 1'b1;
      r_an    <= 4'hF;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_idx   <= w_idx_nxt;
      r_seg   <= w_seg_nxt;
      r_dp    <= w_dp_nxt;
      r_an    <= w_an_nxt;
    end
  end

  assign seg         = r_seg;
  assign dp          = r_dp;
  assign an          = r_an;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_seg_hex_display.sv
// Bench for seg_hex_display: directed display scenarios plus random loads, every cycle
// compared against a slot/frame arithmetic model of the scanned display.
module tb_seg_hex_display;

  localparam int CLK_HZ = 16;
  localparam int REFRESH_HZ = 1;
  localparam int BLANK = 2;
  localparam int SLOT = CLK_HZ / REFRESH_HZ;

`ifdef SEG_LZB_EN
  localparam logic [6:0] DIG3_ZERO = 7'h7F;
`else
  localparam logic [6:0] DIG3_ZERO = 7'h40;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load = 1'b0;
  logic [7:0] data = 8'h00;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       dbg_state;

  int checks = 0;
  int failures = 0;

  // Reference model state: edges since reset release, captured byte and load count.
  int         m_k = 0;
  logic [7:0] m_data = 8'h00;
  logic [7:0] m_count = 8'h00;
  logic [3:0] exp_an = 4'hF;
  logic [6:0] exp_seg = 7'h7F;
  logic       exp_dp = 1'b1;
  logic       exp_drive = 1'b0;

  logic [6:0] hex_lut [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seg_hex_display #(
    .CLK_HZ(CLK_HZ),
    .REFRESH_HZ(REFRESH_HZ),
    .BLANK_CYCLES(BLANK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .load(load),
    .data(data),
    .seg(seg),
    .dp(dp),
    .an(an),
    .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Display seen after edge k: position in slot and digit chosen by plain arithmetic.
  task automatic predict(input int k, input logic [7:0] d, input logic [7:0] c);
    int pos;
    int dig;
    logic [3:0] nib;
    pos = k % SLOT;
    dig = (k / SLOT) % 4;
    exp_an = 4'hF;
    exp_seg = 7'h7F;
    exp_dp = 1'b1;
    exp_drive = 1'b0;
    if (pos >= BLANK) begin
      exp_drive = 1'b1;
      exp_an = 4'hF & ~(4'(1) << dig);
      case (dig)
        0: nib = d[3:0];
        1: nib = d[7:4];
        2: nib = c[3:0];
        default: nib = c[7:4];
      endcase
      exp_seg = ~hex_lut[nib];
      exp_dp = (dig != 2);
`ifdef SEG_LZB_EN
      if (dig == 3 && c < 8'd16) exp_seg = 7'h7F;
`endif
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_k = 0;
      m_data = 8'h00;
      m_count = 8'h00;
      predict(0, 8'h00, 8'h00);
      exp_an = 4'hF;
      exp_seg = 7'h7F;
      exp_dp = 1'b1;
      exp_drive = 1'b0;
    end else begin
      m_k = m_k + 1;
      predict(m_k, m_data, m_count);
      if (load) begin
        m_data = data;
        m_count = m_count + 8'd1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One cycle: compare all outputs with the model at the falling edge, then drive inputs.
  task automatic cyc(input logic ld, input logic [7:0] d);
    @(negedge clk);
    chk("an", 32'(an), 32'(exp_an));
    chk("seg", 32'(seg), 32'(exp_seg));
    chk("dp", 32'(dp), 32'(exp_dp));
    chk("state", 32'(dbg_state), 32'(exp_drive));
    load = ld;
    data = d;
  endtask

  task automatic goto_k(input int target);
    int guard;
    guard = 0;
    while (m_k < target && guard < 4000) begin
      cyc(1'b0, 8'h00);
      guard++;
    end
    chk("goto_k", 32'(m_k), 32'(target));
  endtask

  initial begin
    #2 rst = 1'b1;
    #1;
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'h1);
    @(negedge clk);
    rst = 1'b0;

    cyc(1'b0, 8'h00);
    chk("first_blank_an", 32'(an), 32'hF);
    cyc(1'b0, 8'h00);
    chk("first_drive_an", 32'(an), 32'hE);
    chk("first_drive_seg", 32'(seg), 32'h40);

    cyc(1'b1, 8'hA5);
    cyc(1'b0, 8'h00);
    chk("load_latency_old", 32'(seg), 32'h40);
    cyc(1'b0, 8'h00);
    chk("dig0_5", 32'(seg), 32'h12);
    goto_k(18);
    chk("dig1_an", 32'(an), 32'hD);
    chk("dig1_A", 32'(seg), 32'h08);

    cyc(1'b1, 8'hA5);
    cyc(1'b0, 8'h00);
    cyc(1'b1, 8'hA5);
    goto_k(34);
    chk("dig2_an", 32'(an), 32'hB);
    chk("dig2_3", 32'(seg), 32'h30);
    chk("dig2_dp", 32'(dp), 32'h0);
    goto_k(50);
    chk("dig3_an", 32'(an), 32'h7);
    chk("dig3_0", 32'(seg), 32'(DIG3_ZERO));
    chk("dig3_dp", 32'(dp), 32'h1);

    goto_k(66);
    cyc(1'b1, 8'h3C);
    cyc(1'b0, 8'h00);
    chk("midslot_old", 32'(seg), 32'h12);
    cyc(1'b0, 8'h00);
    chk("midslot_C", 32'(seg), 32'h46);
    goto_k(79);
    chk("slot_end_an", 32'(an), 32'hE);
    cyc(1'b0, 8'h00);
    chk("slot_gap_an", 32'(an), 32'hF);

    goto_k(100);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_an", 32'(an), 32'hF);
    chk("midrst_seg", 32'(seg), 32'h7F);
    chk("midrst_dp", 32'(dp), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b0, 8'h00);
    chk("rerst_blank", 32'(an), 32'hF);
    cyc(1'b0, 8'h00);
    chk("rerst_dig0", 32'(an), 32'hE);

    for (int i = 0; i < 256; i++) begin
      cyc(1'b1, 8'($urandom));
      cyc(1'b0, 8'h00);
    end
    goto_k(610);
    chk("wrap_dig2", 32'(seg), 32'h40);
    goto_k(626);
    chk("wrap_dig3", 32'(seg), 32'(DIG3_ZERO));

    for (int i = 0; i < 2000; i++) begin
      cyc(($urandom_range(0, 3) == 0), 8'($urandom));
    end
    cyc(1'b0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
